nibble_add_arbiter: RTL and testbench

//   Shares one DATA_W-bit adder among NUM_REQ requesters.

---
 rtl/nibble_add_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/nibble_add_arbiter.sv | 131 +++++++++++++
 tb/tb_nibble_add_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_add_pkg.sv
// ---------------------------------------------------------------------------
// nibble_add_pkg
//   Shared definitions for the nibble adder arbiter:
//     DATA_W / NUM_REQ : default operand width and requester count
//     nibble_t         : one operand
//     sum_t            : operand width plus one carry bit
//     rr_wrap()        : (base + off) modulo n for base < n, off <= n.
//                        Used by the arbiter's priority search and by the
//                        round-robin pointer update.
// ---------------------------------------------------------------------------
package nibble_add_pkg;

  localparam int DATA_W  = 4;
  localparam int NUM_REQ = 4;

  typedef logic [DATA_W-1:0] nibble_t;
  typedef logic [DATA_W:0]   sum_t;

  // A single conditional subtract is enough because base < n and off <= n.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    int unsigned s;
    s = base + off;
    if (s >= n) begin
      s = s - n;
    end
    return s;
  endfunction

endpackage : nibble_add_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick. Searches req starting at ptr,
//   then ptr+1, ... modulo N, and grants the first asserted request.
//   Ports:
//     req     [N]    in   request vector
//     ptr     [IDW]  in   highest-priority index (must be < N)
//     en      1      in   when low, no grant is issued
//     gnt     [N]    out  one-hot grant (all-zero when nothing granted)
//     gnt_idx [IDW]  out  index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  import nibble_add_pkg::*;

  localparam int IDW = $clog2(N);

  logic [IDW-1:0] w_cand;
  logic           w_found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_cand = IDW'(rr_wrap(32'(ptr), 32'(k), 32'(N)));
      if (en && !w_found && req[w_cand]) begin
        w_found        = 1'b1;
        gnt[w_cand]    = 1'b1;
        gnt_idx        = w_cand;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/nibble_add_arbiter.sv
// ---------------------------------------------------------------------------
// nibble_add_arbiter
//   Shares one DATA_W-bit adder among NUM_REQ requesters. A round-robin
//   arbiter picks one valid requester per cycle, its operands are added
//   DATA_W+1 wide, and the result lands in a one-entry response slot.
//   Throughput is one addition per cycle while the consumer keeps up.
//
//   Optional feature (compile-time macro SATURATE_EN):
//     defined   : rsp_sum is forced to all-ones whenever the carry is set
//     undefined : rsp_sum is the sum modulo 2**DATA_W
//   rsp_carry reports the overflow in both builds; timing is identical.
//
//   Ports:
//     clk        in   1               clock, rising edge
//     reset      in   1               synchronous reset, active-high
//     req_valid  in   NUM_REQ         requester i has operands valid
//     req_ready  out  NUM_REQ         one-hot grant (combinational)
//     req_a      in   NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
//     req_b      in   NUM_REQ*DATA_W  operand B, same packing
//     rsp_valid  out  1               response slot holds a result
//     rsp_ready  in   1               consumer accepts the response
//     rsp_sum    out  DATA_W          sum (saturated in the SATURATE_EN build)
//     rsp_carry  out  1               carry-out of the addition
//     rsp_id     out  IDW             requester that produced the result
//     rr_ptr     out  IDW             current highest-priority requester
// ---------------------------------------------------------------------------
module nibble_add_arbiter #(
  parameter int NUM_REQ = nibble_add_pkg::NUM_REQ,  // 2..8
  parameter int DATA_W  = nibble_add_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_sum,
  output logic                       rsp_carry,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [$clog2(NUM_REQ)-1:0] rr_ptr
);

  localparam int IDW = $clog2(NUM_REQ);

  // Response slot and round-robin pointer
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_sum;
  logic              r_rsp_carry;
  logic [IDW-1:0]    r_rsp_id;
  logic [IDW-1:0]    r_rr_ptr;

  logic               w_slot_free;
  logic               w_arb_en;
  logic               w_xfer;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDW-1:0]     w_gnt_idx;
  logic [IDW-1:0]     w_ptr_next;
  logic [DATA_W-1:0]  w_a_arr [NUM_REQ];
  logic [DATA_W-1:0]  w_b_arr [NUM_REQ];
  logic [DATA_W-1:0]  w_a;
  logic [DATA_W-1:0]  w_b;
  logic [DATA_W:0]    w_sum;
  logic [DATA_W-1:0]  w_sum_out;

  // The slot can take a new result if it is empty or being drained now.
  assign w_slot_free = !r_rsp_valid || rsp_ready;

  // Grants are suppressed while reset is high so no requester believes it
  // was accepted on a cycle whose result is about to be discarded.
  assign w_arb_en = w_slot_free && !reset;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign req_ready = w_gnt;
  assign w_xfer    = |(req_valid & w_gnt);

  // Unpack the flat operand buses so the mux is a plain array index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
    assign w_b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
  end

  assign w_a   = w_a_arr[w_gnt_idx];
  assign w_b   = w_b_arr[w_gnt_idx];
  assign w_sum = {1'b0, w_a} + {1'b0, w_b};

`ifdef SATURATE_EN
  assign w_sum_out = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`else
  assign w_sum_out = w_sum[DATA_W-1:0];
`endif

  assign w_ptr_next = IDW'(nibble_add_pkg::rr_wrap(32'(w_gnt_idx), 32'd1, 32'(NUM_REQ)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_id    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_xfer) begin
      // Covers both an empty slot and drain-plus-reload in the same cycle.
      r_rsp_valid <= 1'b1;
      r_rsp_sum   <= w_sum_out;
      r_rsp_carry <= w_sum[DATA_W];
      r_rsp_id    <= w_gnt_idx;
      r_rr_ptr    <= w_ptr_next;
    end else if (rsp_ready) begin
      // Data fields keep their last value after a drain.
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_carry = r_rsp_carry;
  assign rsp_id    = r_rsp_id;
  assign rr_ptr    = r_rr_ptr;

endmodule : nibble_add_arbiter

// File: tb/tb_nibble_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nibble_add_arbiter
//   Directed bench for nibble_add_arbiter (NUM_REQ=4, DATA_W=4). Inputs are
//   driven and outputs sampled on the falling clock edge. Honours
//   SATURATE_EN for the expected sum values.
// ---------------------------------------------------------------------------
module tb_nibble_add_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_sum;
    logic        rsp_carry;
    logic [1:0]  rsp_id;
    logic [1:0]  rr_ptr;

    int checks = 0;
    int errors = 0;

    // Per-requester operands:
    //   r0: 3+4 = 7, c0   r1: F+1 = 0, c1   r2: 9+8 = 1, c1   r3: 6+6 = C, c0
    logic [3:0] exp_s [4];
    logic       exp_c [4];
    int         order [6];

    nibble_add_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id),
        .rr_ptr    (rr_ptr)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish within 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef SATURATE_EN
        exp_s[0] = 4'h7; exp_s[1] = 4'hF; exp_s[2] = 4'hF; exp_s[3] = 4'hC;
`else
        exp_s[0] = 4'h7; exp_s[1] = 4'h0; exp_s[2] = 4'h1; exp_s[3] = 4'hC;
`endif
        exp_c[0] = 1'b0; exp_c[1] = 1'b1; exp_c[2] = 1'b1; exp_c[3] = 1'b0;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0; order[5] = 1;

        // ---- 1. reset with every requester valid ----
        reset     = 1'b1;
        req_valid = 4'hF;
        req_a     = 16'h69F3;
        req_b     = 16'h6814;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rst_rdy_c1: observed %0h expected 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: observed %0h expected 0", rsp_valid); end
        checks++; if (rr_ptr !== 2'd0) begin errors++; $display("FAIL rst_ptr: observed %0h expected 0", rr_ptr); end
        @(negedge clk);
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL rst_rdy_c2: observed %0h expected 0", req_ready); end
        checks++; if (rsp_sum !== 4'h0) begin errors++; $display("FAIL rst_sum: observed %0h expected 0", rsp_sum); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL rst_id: observed %0h expected 0", rsp_id); end
        reset     = 1'b0;
        req_valid = 4'h0;
        #1;
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL idle_rdy: observed %0h expected 0", req_ready); end
        $display("step reset: rsp_valid=%0b rr_ptr=%0d", rsp_valid, rr_ptr);

        // ---- 2. requester 2 alone, 9+8 ----
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL r2_rdy: observed %0h expected 4", req_ready); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL r2_valid: observed %0h expected 1", rsp_valid); end
        checks++; if (rsp_sum !== exp_s[2]) begin errors++; $display("FAIL r2_sum: observed %0h expected %0h", rsp_sum, exp_s[2]); end
        checks++; if (rsp_carry !== 1'b1) begin errors++; $display("FAIL r2_carry: observed %0h expected 1", rsp_carry); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL r2_id: observed %0h expected 2", rsp_id); end
        checks++; if (rr_ptr !== 2'd3) begin errors++; $display("FAIL r2_ptr: observed %0h expected 3", rr_ptr); end
        $display("step r2: sum=%0h carry=%0b id=%0d ptr=%0d", rsp_sum, rsp_carry, rsp_id, rr_ptr);
        req_valid = 4'h0;
        #1;
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL r2_norq_rdy: observed %0h expected 0", req_ready); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: observed %0h expected 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL drain_id_hold: observed %0h expected 2", rsp_id); end
        checks++; if (rr_ptr !== 2'd3) begin errors++; $display("FAIL drain_ptr_hold: observed %0h expected 3", rr_ptr); end

        // ---- bring rr_ptr to 0 via requester 3 ----
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL r3_rdy: observed %0h expected 8", req_ready); end
        @(negedge clk);
        checks++; if (rsp_sum !== 4'hC) begin errors++; $display("FAIL r3_sum: observed %0h expected c", rsp_sum); end
        checks++; if (rsp_id !== 2'd3) begin errors++; $display("FAIL r3_id: observed %0h expected 3", rsp_id); end
        checks++; if (rr_ptr !== 2'd0) begin errors++; $display("FAIL r3_ptr_wrap: observed %0h expected 0", rr_ptr); end

        // ---- 3. all requesters valid continuously ----
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (req_ready !== 4'(1 << order[k])) begin errors++; $display("FAIL rr_rdy: observed %0h expected %0h", req_ready, 4'(1 << order[k])); end
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid: observed %0h expected 1", rsp_valid); end
            checks++; if (rsp_id !== 2'(order[k])) begin errors++; $display("FAIL rr_id: observed %0h expected %0h", rsp_id, order[k]); end
            checks++; if (rsp_sum !== exp_s[order[k]]) begin errors++; $display("FAIL rr_sum: observed %0h expected %0h", rsp_sum, exp_s[order[k]]); end
            checks++; if (rsp_carry !== exp_c[order[k]]) begin errors++; $display("FAIL rr_carry: observed %0h expected %0h", rsp_carry, exp_c[order[k]]); end
            $display("step rr%0d: id=%0d sum=%0h carry=%0b ptr=%0d", k, rsp_id, rsp_sum, rsp_carry, rr_ptr);
        end
        checks++; if (rr_ptr !== 2'd2) begin errors++; $display("FAIL rr_ptr_end: observed %0h expected 2", rr_ptr); end

        // ---- 4. back-pressure for 3 cycles ----
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL bp_rdy: observed %0h expected 0", req_ready); end
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: observed %0h expected 1", rsp_valid); end
            checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL bp_id: observed %0h expected 1", rsp_id); end
            checks++; if (rsp_sum !== exp_s[1]) begin errors++; $display("FAIL bp_sum: observed %0h expected %0h", rsp_sum, exp_s[1]); end
            checks++; if (rsp_carry !== 1'b1) begin errors++; $display("FAIL bp_carry: observed %0h expected 1", rsp_carry); end
            checks++; if (rr_ptr !== 2'd2) begin errors++; $display("FAIL bp_ptr: observed %0h expected 2", rr_ptr); end
            $display("step bp%0d: id=%0d sum=%0h ptr=%0d", k, rsp_id, rsp_sum, rr_ptr);
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_rdy: observed %0h expected 4", req_ready); end
        @(negedge clk);
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL bp_release_id: observed %0h expected 2", rsp_id); end
        checks++; if (rsp_sum !== exp_s[2]) begin errors++; $display("FAIL bp_release_sum: observed %0h expected %0h", rsp_sum, exp_s[2]); end
        checks++; if (rr_ptr !== 2'd3) begin errors++; $display("FAIL bp_release_ptr: observed %0h expected 3", rr_ptr); end

        // ---- 5. requesters 1 and 3 with rr_ptr=2 ----
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL w_setup_rdy: observed %0h expected 2", req_ready); end
        @(negedge clk);
        checks++; if (rr_ptr !== 2'd2) begin errors++; $display("FAIL w_setup_ptr: observed %0h expected 2", rr_ptr); end
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL w_first_rdy: observed %0h expected 8", req_ready); end
        @(negedge clk);
        checks++; if (rsp_id !== 2'd3) begin errors++; $display("FAIL w_first_id: observed %0h expected 3", rsp_id); end
        checks++; if (rr_ptr !== 2'd0) begin errors++; $display("FAIL w_first_ptr: observed %0h expected 0", rr_ptr); end
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL w_second_rdy: observed %0h expected 2", req_ready); end
        @(negedge clk);
        checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL w_second_id: observed %0h expected 1", rsp_id); end
        checks++; if (rsp_sum !== exp_s[1]) begin errors++; $display("FAIL w_second_sum: observed %0h expected %0h", rsp_sum, exp_s[1]); end
        checks++; if (rr_ptr !== 2'd2) begin errors++; $display("FAIL w_second_ptr: observed %0h expected 2", rr_ptr); end
        $display("step wrap: id=%0d ptr=%0d", rsp_id, rr_ptr);

        // ---- 6. reset while a response is stalled ----
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL pend_valid: observed %0h expected 1", rsp_valid); end
        checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL pend_id: observed %0h expected 1", rsp_id); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: observed %0h expected 0", rsp_valid); end
        checks++; if (rr_ptr !== 2'd0) begin errors++; $display("FAIL mid_rst_ptr: observed %0h expected 0", rr_ptr); end
        checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL mid_rst_rdy: observed %0h expected 0", req_ready); end
        reset     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'h0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: observed %0h expected 0", rsp_valid); end
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL post_rst_rdy: observed %0h expected 4", req_ready); end
        @(negedge clk);
        checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL post_rst_id: observed %0h expected 2", rsp_id); end
        checks++; if (rr_ptr !== 2'd3) begin errors++; $display("FAIL post_rst_ptr: observed %0h expected 3", rr_ptr); end
        $display("step reset_mid: valid=%0b id=%0d ptr=%0d", rsp_valid, rsp_id, rr_ptr);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_nibble_add_arbiter
